stack_seq: RTL and testbench

STACK_SEQ -- requirements
Module: stack_seq

---
 rtl/stack_seq.sv | 186 ++++++++++++++++++
 tb/tb_stack_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/stack_seq.sv
// Stack sequencer: register-held top plus a registered-read array for lower entries.
// Optional DUP/SWAP opcodes are built when STACK_SEQ_EXT_OPS_EN is defined.
module stack_seq #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data,
    input  logic             err_clr,
    output logic [WIDTH-1:0] top,
    output logic [9:0]       depth,
    output logic             done,
    output logic [2:0]       err
);

    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;
    localparam logic [9:0] DMAX = 10'(DEPTH);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_MUL  = 3'd5;
    localparam logic [2:0] OP_DUP  = 3'd6;
    localparam logic [2:0] OP_SWAP = 3'd7;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_FETCH = 1'b1;

    logic             state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] top_q, top_d;
    logic [9:0]       depth_q, depth_d;
    logic             done_q, done_d;
    logic [2:0]       err_q, err_d;

    logic [WIDTH-1:0] mem [DEPTH-1];
    logic [WIDTH-1:0] rd_data;
    logic             we, re;
    logic [AW-1:0]    waddr, raddr;
    logic [AW-1:0]    addr_m1, addr_m2;

    assign addr_m1 = AW'(depth_q - 10'd1);
    assign addr_m2 = AW'(depth_q - 10'd2);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        top_d   = top_q;
        depth_d = depth_q;
        done_d  = 1'b0;
        err_d   = err_clr ? 3'b000 : err_q;
        we      = 1'b0;
        waddr   = addr_m1;
        re      = 1'b0;
        raddr   = addr_m2;

        if (state_q == ST_IDLE) begin
            if (op_valid) begin
                op_d   = op;
                done_d = 1'b1;
                case (op)
                    OP_NOP: ;
                    OP_PUSH: begin
                        if (depth_q == DMAX) begin
                            err_d[0] = 1'b1;
                        end else begin
                            we      = (depth_q != 10'd0);
                            top_d   = data;
                            depth_d = depth_q + 10'd1;
                        end
                    end
                    OP_POP: begin
                        if (depth_q == 10'd0) begin
                            err_d[1] = 1'b1;
                        end else if (depth_q == 10'd1) begin
                            top_d   = '0;
                            depth_d = 10'd0;
                        end else begin
                            re      = 1'b1;
                            state_d = ST_FETCH;
                            done_d  = 1'b0;
                        end
                    end
                    OP_ADD, OP_SUB, OP_MUL: begin
                        if (depth_q < 10'd2) begin
                            err_d[1] = 1'b1;
                        end else begin
                            re      = 1'b1;
                            state_d = ST_FETCH;
                            done_d  = 1'b0;
                        end
                    end
`ifdef STACK_SEQ_EXT_OPS_EN
                    OP_DUP: begin
                        if (depth_q == 10'd0) begin
                            err_d[1] = 1'b1;
                        end else if (depth_q == DMAX) begin
                            err_d[0] = 1'b1;
                        end else begin
                            we      = 1'b1;
                            depth_d = depth_q + 10'd1;
                        end
                    end
                    OP_SWAP: begin
                        if (depth_q < 10'd2) begin
                            err_d[1] = 1'b1;
                        end else begin
                            re      = 1'b1;
                            state_d = ST_FETCH;
                            done_d  = 1'b0;
                        end
                    end
`endif
                    default: err_d[2] = 1'b1;
                endcase
            end
        end else begin
            // rd_data now holds the entry just below top
            state_d = ST_IDLE;
            done_d  = 1'b1;
            case (op_q)
                OP_POP: begin
                    top_d   = rd_data;
                    depth_d = depth_q - 10'd1;
                end
                OP_ADD: begin
                    top_d   = rd_data + top_q;
                    depth_d = depth_q - 10'd1;
                end
                OP_SUB: begin
                    top_d   = rd_data - top_q;
                    depth_d = depth_q - 10'd1;
                end
                OP_MUL: begin
                    top_d   = rd_data * top_q;
                    depth_d = depth_q - 10'd1;
                end
`ifdef STACK_SEQ_EXT_OPS_EN
                OP_SWAP: begin
                    we    = 1'b1;
                    waddr = addr_m2;
                    top_d = rd_data;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            top_q   <= '0;
            depth_q <= 10'd0;
            done_q  <= 1'b0;
            err_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            top_q   <= top_d;
            depth_q <= depth_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Array is deliberately not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= top_q;
        if (re) rd_data <= mem[raddr];
    end

    assign op_ready = (state_q == ST_IDLE);
    assign top      = top_q;
    assign depth    = depth_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_stack_seq.sv
// Directed bench for stack_seq: a vector table plus hand sequences for overflow,
// FETCH hold, mid-FETCH reset and the STACK_SEQ_EXT_OPS_EN opcodes.
module tb_stack_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op;
    logic [15:0] data;
    logic        err_clr;
    logic [15:0] top;
    logic [9:0]  depth;
    logic        done;
    logic [2:0]  err;

    int n_vec  = 0;
    int n_miss = 0;

    stack_seq #(.WIDTH(16), .DEPTH(1000)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op       (op),
        .data     (data),
        .err_clr  (err_clr),
        .top      (top),
        .depth    (depth),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] data;
        logic        clr;
        logic [15:0] top;
        logic [9:0]  depth;
        logic [2:0]  err;
        int          lat;
    } vec_t;

    vec_t vtab[$];

    task automatic add(input logic [2:0] o, input logic [15:0] d, input logic c,
                       input logic [15:0] t, input logic [9:0] dp, input logic [2:0] e,
                       input int l);
        vec_t v;
        v.op = o; v.data = d; v.clr = c; v.top = t; v.depth = dp; v.err = e; v.lat = l;
        vtab.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one op at a negedge, then count negedges until done (bounded).
    task automatic do_op(input logic [2:0] o, input logic [15:0] d, input logic c,
                         output int lat);
        int w;
        w = 0;
        while (!op_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        op_valid = 1'b1; op = o; data = d; err_clr = c;
        @(negedge clk);
        op_valid = 1'b0; err_clr = 1'b0;
        lat = 1;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        op_valid = 1'b0; op = 3'd0; data = '0; err_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int lat;

        // Reset state
        do_reset();
        check("reset top", 32'(top), 32'h0);
        check("reset depth", 32'(depth), 32'h0);
        check("reset err", 32'(err), 32'h0);
        check("reset ready", 32'(op_ready), 32'h1);
        check("reset done", 32'(done), 32'h0);

        add(3'd1, 16'h0005, 1'b0, 16'h0005, 10'd1, 3'b000, 1);
        add(3'd1, 16'h0007, 1'b0, 16'h0007, 10'd2, 3'b000, 1);
        add(3'd3, 16'h0000, 1'b0, 16'h000C, 10'd1, 3'b000, 2);
        add(3'd2, 16'h0000, 1'b0, 16'h0000, 10'd0, 3'b000, 1);
        add(3'd2, 16'h0000, 1'b0, 16'h0000, 10'd0, 3'b010, 1);
        add(3'd0, 16'h0000, 1'b1, 16'h0000, 10'd0, 3'b000, 1);
        add(3'd1, 16'h0003, 1'b0, 16'h0003, 10'd1, 3'b000, 1);
        add(3'd1, 16'h000A, 1'b0, 16'h000A, 10'd2, 3'b000, 1);
        add(3'd4, 16'h0000, 1'b0, 16'hFFF9, 10'd1, 3'b000, 2);
        add(3'd2, 16'h0000, 1'b0, 16'h0000, 10'd0, 3'b000, 1);
        add(3'd1, 16'h0100, 1'b0, 16'h0100, 10'd1, 3'b000, 1);
        add(3'd1, 16'h0100, 1'b0, 16'h0100, 10'd2, 3'b000, 1);
        add(3'd5, 16'h0000, 1'b0, 16'h0000, 10'd1, 3'b000, 2);
        add(3'd3, 16'h0000, 1'b0, 16'h0000, 10'd1, 3'b010, 1);
        add(3'd0, 16'h0000, 1'b1, 16'h0000, 10'd1, 3'b000, 1);
        add(3'd1, 16'hFFFF, 1'b0, 16'hFFFF, 10'd2, 3'b000, 1);
        add(3'd1, 16'h0002, 1'b0, 16'h0002, 10'd3, 3'b000, 1);
        add(3'd3, 16'h0000, 1'b0, 16'h0001, 10'd2, 3'b000, 2);
        add(3'd5, 16'h0000, 1'b0, 16'h0000, 10'd1, 3'b000, 2);

        foreach (vtab[i]) begin
            do_op(vtab[i].op, vtab[i].data, vtab[i].clr, lat);
            check($sformatf("vec%0d lat", i), 32'(lat), 32'(vtab[i].lat));
            check($sformatf("vec%0d top", i), 32'(top), 32'(vtab[i].top));
            check($sformatf("vec%0d depth", i), 32'(depth), 32'(vtab[i].depth));
            check($sformatf("vec%0d err", i), 32'(err), 32'(vtab[i].err));
        end

        // op_valid held through FETCH must not be accepted twice
        do_reset();
        do_op(3'd1, 16'h0004, 1'b0, lat);
        do_op(3'd1, 16'h0006, 1'b0, lat);
        op_valid = 1'b1; op = 3'd3;
        @(negedge clk);
        check("hold ready", 32'(op_ready), 32'h0);
        @(negedge clk);
        op_valid = 1'b0;
        check("hold done", 32'(done), 32'h1);
        check("hold top", 32'(top), 32'h000A);
        @(negedge clk);
        @(negedge clk);
        check("hold depth", 32'(depth), 32'h1);
        check("hold err", 32'(err), 32'h0);
        check("hold done2", 32'(done), 32'h0);

        // Reset in the middle of FETCH
        do_op(3'd1, 16'h0008, 1'b0, lat);
        op_valid = 1'b1; op = 3'd3;
        @(negedge clk);
        op_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst depth", 32'(depth), 32'h0);
        check("midrst top", 32'(top), 32'h0);
        check("midrst ready", 32'(op_ready), 32'h1);
        check("midrst done", 32'(done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        op_valid = 1'b1; op = 3'd1; data = 16'h0009;
        @(negedge clk);
        op_valid = 1'b0;
        check("postrst done", 32'(done), 32'h1);
        check("postrst top", 32'(top), 32'h0009);
        check("postrst depth", 32'(depth), 32'h1);

        // Fill to DEPTH, overflow, then unwind
        do_reset();
        do_op(3'd2, 16'h0000, 1'b0, lat);
        check("empty pop err", 32'(err), 32'b010);
        do_op(3'd1, 16'hABCD, 1'b0, lat);
        for (int i = 1; i < 1000; i++) do_op(3'd1, 16'(i), 1'b0, lat);
        check("full depth", 32'(depth), 32'd1000);
        check("full top", 32'(top), 32'd999);
        do_op(3'd1, 16'h5555, 1'b1, lat);
        check("ovf lat", 32'(lat), 32'h1);
        check("ovf err", 32'(err), 32'b001);
        check("ovf depth", 32'(depth), 32'd1000);
        check("ovf top", 32'(top), 32'd999);
        for (int i = 0; i < 999; i++) do_op(3'd2, 16'h0000, 1'b0, lat);
        check("unwind top", 32'(top), 32'hABCD);
        check("unwind depth", 32'(depth), 32'h1);

        // DUP / SWAP
        do_reset();
        do_op(3'd1, 16'h0001, 1'b0, lat);
        do_op(3'd1, 16'h0002, 1'b0, lat);
`ifdef STACK_SEQ_EXT_OPS_EN
        do_op(3'd7, 16'h0000, 1'b0, lat);
        check("swap lat", 32'(lat), 32'h2);
        check("swap top", 32'(top), 32'h1);
        check("swap depth", 32'(depth), 32'h2);
        do_op(3'd2, 16'h0000, 1'b0, lat);
        check("swap pop top", 32'(top), 32'h2);
        do_op(3'd6, 16'h0000, 1'b0, lat);
        check("dup lat", 32'(lat), 32'h1);
        check("dup depth", 32'(depth), 32'h2);
        do_op(3'd3, 16'h0000, 1'b0, lat);
        check("dup add top", 32'(top), 32'h4);
        check("ext err", 32'(err), 32'h0);
`else
        do_op(3'd7, 16'h0000, 1'b0, lat);
        check("swap lat", 32'(lat), 32'h1);
        check("swap err", 32'(err), 32'b100);
        check("swap top", 32'(top), 32'h2);
        check("swap depth", 32'(depth), 32'h2);
        do_op(3'd6, 16'h0000, 1'b1, lat);
        check("dup err", 32'(err), 32'b100);
        check("dup depth", 32'(depth), 32'h2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
